// File: rtl/cga_mac_segpt_segbank.sv
// Per-level segment bank with LIFO save stack; SEG/SEGZN registered, 1-cycle latency.
// No backpressure: stack misuse is dropped and flagged on sticky STKERR.
module cga_mac_segpt_segbank #(
    parameter int WIDTH       = 8,
    parameter int LEVELS      = 16,
    parameter int LVL_W       = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] FIDBO,
    input  logic             LLDSEG,
    input  logic [LVL_W-1:0] LDLVL,
    input  logic [LVL_W-1:0] ACTLVL,
    input  logic             SAVE,
    input  logic             RESTORE,
    input  logic             CLRERR,
    output logic [WIDTH-1:0] SEG,
    output logic             SEGZN,
    output logic             STKFULL,
    output logic             STKEMPTY,
    output logic             STKERR
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    generate
        if (LVL_W != $clog2(LEVELS)) begin : g_bad_lvl_w
            $error("LVL_W must equal clog2(LEVELS)");
        end
    endgenerate

    logic [WIDTH-1:0] r_bank  [LEVELS];
    logic [WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic [WIDTH-1:0] r_seg;
    logic             r_segzn;
    logic             r_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_err;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_seg_next;

    assign w_full  = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty = (r_sp == '0);
    assign w_push  = SAVE & ~RESTORE & ~w_full;
    assign w_pop   = RESTORE & ~SAVE & ~w_empty;
    assign w_err   = (SAVE & RESTORE) | (SAVE & w_full) | (RESTORE & w_empty);

    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SP_W'(i + 1)) w_top = r_stack[i];
        end
    end

    // Load beats restore when both target the active level
    always_comb begin
        w_seg_next = r_bank[ACTLVL];
        if (w_pop) w_seg_next = w_top;
        if (LLDSEG && (LDLVL == ACTLVL)) w_seg_next = FIDBO;
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < LEVELS; i++) r_bank[i] <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
            r_sp    <= '0;
            r_seg   <= '0;
            r_segzn <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_pop) r_bank[ACTLVL] <= w_top;
            if (LLDSEG) r_bank[LDLVL] <= FIDBO;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (w_push && (r_sp == SP_W'(i))) r_stack[i] <= r_bank[ACTLVL];
            end
            if (w_push)     r_sp <= r_sp + SP_W'(1);
            else if (w_pop) r_sp <= r_sp - SP_W'(1);
            r_seg   <= w_seg_next;
            r_segzn <= |w_seg_next;
            if (w_err)       r_err <= 1'b1;
            else if (CLRERR) r_err <= 1'b0;
        end
    end

    assign SEG      = r_seg;
    assign SEGZN    = r_segzn;
    assign STKFULL  = w_full;
    assign STKEMPTY = w_empty;
    assign STKERR   = r_err;

endmodule

// File: tb/tb_cga_mac_segpt_segbank.sv
// Directed plus randomized bench for cga_mac_segpt_segbank against a queue-based model.
module tb_cga_mac_segpt_segbank;

    localparam int DEPTH = 4;

    logic       sysclk = 1'b0;
    logic       sys_rst;
    logic [7:0] FIDBO;
    logic       LLDSEG;
    logic [3:0] LDLVL;
    logic [3:0] ACTLVL;
    logic       SAVE;
    logic       RESTORE;
    logic       CLRERR;
    logic [7:0] SEG;
    logic       SEGZN;
    logic       STKFULL;
    logic       STKEMPTY;
    logic       STKERR;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_bank [16];
    logic [7:0] m_stk  [$];
    logic [7:0] m_seg;
    logic       m_err;

    cga_mac_segpt_segbank dut (
        .sysclk  (sysclk),
        .sys_rst (sys_rst),
        .FIDBO   (FIDBO),
        .LLDSEG  (LLDSEG),
        .LDLVL   (LDLVL),
        .ACTLVL  (ACTLVL),
        .SAVE    (SAVE),
        .RESTORE (RESTORE),
        .CLRERR  (CLRERR),
        .SEG     (SEG),
        .SEGZN   (SEGZN),
        .STKFULL (STKFULL),
        .STKEMPTY(STKEMPTY),
        .STKERR  (STKERR)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
        m_stk.delete();
        m_seg = 8'h00;
        m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".SEG"},      {24'h0, SEG},      {24'h0, m_seg});
        chk({tag, ".SEGZN"},    {31'h0, SEGZN},    {31'h0, (m_seg != 8'h00)});
        chk({tag, ".STKFULL"},  {31'h0, STKFULL},  {31'h0, (m_stk.size() == DEPTH)});
        chk({tag, ".STKEMPTY"}, {31'h0, STKEMPTY}, {31'h0, (m_stk.size() == 0)});
        chk({tag, ".STKERR"},   {31'h0, STKERR},   {31'h0, m_err});
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1ns later
    task automatic step(input string tag, input logic ld, input logic [3:0] ll,
                        input logic [7:0] d, input logic [3:0] al,
                        input logic sv, input logic rs, input logic cl);
        logic err_now;
        LLDSEG = ld; LDLVL = ll; FIDBO = d; ACTLVL = al;
        SAVE = sv; RESTORE = rs; CLRERR = cl;
        @(posedge sysclk);
        err_now = 1'b0;
        if (sv && rs) begin
            err_now = 1'b1;
        end else if (sv) begin
            if (m_stk.size() == DEPTH) err_now = 1'b1;
            else m_stk.push_back(m_bank[al]);
        end else if (rs) begin
            if (m_stk.size() == 0) err_now = 1'b1;
            else m_bank[al] = m_stk.pop_back();
        end
        if (ld) m_bank[ll] = d;
        m_seg = m_bank[al];
        if (err_now) m_err = 1'b1;
        else if (cl) m_err = 1'b0;
        #1;
        check_all(tag);
    endtask

    initial begin
        sys_rst = 1'b1;
        LLDSEG = 0; LDLVL = 0; FIDBO = 0; ACTLVL = 0;
        SAVE = 0; RESTORE = 0; CLRERR = 0;
        model_reset();
        repeat (2) @(posedge sysclk);
        #1;
        check_all("rst");
        sys_rst = 1'b0;

        step("idle", 0, 0, 8'h00, 0, 0, 0, 0);
        step("ld3", 1, 3, 8'hA5, 3, 0, 0, 0);
        step("act5", 0, 0, 8'h00, 5, 0, 0, 0);

        step("ld2", 1, 2, 8'h11, 2, 0, 0, 0);
        step("sv_ld2", 1, 2, 8'h22, 2, 1, 0, 0);
        step("rs2", 0, 0, 8'h00, 2, 0, 1, 0);

        for (int k = 0; k < DEPTH; k++) begin
            step("fill_ld", 1, 6, 8'h30 + 8'(k), 6, 0, 0, 0);
            step("fill_sv", 0, 0, 8'h00, 6, 1, 0, 0);
        end
        step("ovf", 1, 6, 8'h55, 6, 1, 0, 0);
        for (int k = 0; k < DEPTH; k++) step("lifo", 0, 0, 8'h00, 7, 0, 1, 0);

        step("clr1", 0, 0, 8'h00, 7, 0, 0, 1);
        step("unf", 0, 0, 8'h00, 7, 0, 1, 0);
        step("clr2", 0, 0, 8'h00, 7, 0, 0, 1);
        step("clr_unf", 0, 0, 8'h00, 7, 0, 1, 1);

        step("clr3", 0, 0, 8'h00, 4, 0, 0, 1);
        step("sv_a", 1, 4, 8'h44, 4, 1, 0, 0);
        step("sv_b", 0, 0, 8'h00, 4, 1, 0, 0);
        step("sv_rs", 0, 0, 8'h00, 4, 1, 1, 0);
        step("rs_ld", 1, 4, 8'h7F, 4, 0, 1, 0);
        step("rs_last", 0, 0, 8'h00, 4, 0, 1, 0);

        // Asynchronous reset landing mid-cycle with state present
        step("pre_rst", 1, 1, 8'h9C, 1, 1, 0, 0);
        #2;
        sys_rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge sysclk);
        #1;
        sys_rst = 1'b0;
        step("post_rst", 0, 0, 8'h00, 1, 0, 0, 0);

        for (int n = 0; n < 500; n++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            step("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), d,
                 4'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cga_mac_segpt_segbank.md
Name: cga_mac_segpt_segbank

Overview:
Parametrised successor to the single 8-bit segment register in CGA/MAC/SEGPT. It holds one segment register per privilege/interrupt level (LEVELS entries, WIDTH bits each) and presents the active level's segment with a registered zero flag. It also provides a LIFO save/restore stack for context switches. It sits between the FIDBO data bus and the MAC page-table address path.

Parameters:
WIDTH, 8, segment register width in bits
LEVELS, 16, number of segment registers (power of 2, 2..16)
LVL_W, 4, level-select width; must equal clog2(LEVELS)
STACK_DEPTH, 4, save-stack entries (1..8)

Ports:
sysclk  input  1  system clock; all state changes on the rising edge
sys_rst  input  1  asynchronous, active-high reset
FIDBO  input  WIDTH  load data bus
LLDSEG  input  1  load strobe: write FIDBO into bank[LDLVL]
LDLVL  input  LVL_W  level written by LLDSEG
ACTLVL  input  LVL_W  active level, selects the output and the SAVE/RESTORE target
SAVE  input  1  push bank[ACTLVL] onto the save stack
RESTORE  input  1  pop the stack top into bank[ACTLVL]
CLRERR  input  1  clear STKERR
SEG  output  WIDTH  registered segment of the active level
SEGZN  output  1  registered; 0 when SEG == 0, else 1
STKFULL  output  1  stack holds STACK_DEPTH entries
STKEMPTY  output  1  stack holds 0 entries
STKERR  output  1  sticky stack-misuse flag

Behaviour:
- Reset, asynchronous: all bank entries = 0, stack pointer = 0, stack contents = 0.
- Reset output values: SEG = 0, SEGZN = 0, STKFULL = 0, STKEMPTY = 1, STKERR = 0.
- Release from reset is synchronous to the next sysclk edge.
- Reset asserted mid-operation aborts any in-flight write, push or pop. Nothing is partially committed.
- Bank next-state per edge, evaluated in priority order:
  1. A valid RESTORE writes the stack top into bank[ACTLVL].
  2. LLDSEG writes FIDBO into bank[LDLVL].
  3. If both target the same level, LLDSEG wins and the restore data is discarded. The pop still completes.
- Output pipeline: SEG <= bank_next[ACTLVL] (the value after this edge's writes), and SEGZN <= |bank_next[ACTLVL].
  - Latency from LLDSEG or RESTORE to SEG is 1 cycle. This includes write-to-active-level in the same cycle.
  - A change of ACTLVL with no write is also visible on SEG 1 cycle later.
- SAVE, valid when stack not full:
  - stack[sp] <= bank[ACTLVL] (pre-write value of this cycle); sp <= sp+1.
  - SAVE with a simultaneous LLDSEG to the same level pushes the old value.
- RESTORE, valid when stack not empty: sp <= sp-1; the data is stack[sp-1].
- Stack misuse (sets STKERR, changes no stack state):
  - SAVE when STKFULL: overflow. The push is dropped.
  - RESTORE when STKEMPTY: underflow. The bank is not written from the stack; LLDSEG still acts.
  - SAVE and RESTORE in the same cycle: both are ignored. LLDSEG still acts.
- STKERR behaviour:
  - It is sticky until CLRERR.
  - If CLRERR and a new error occur in the same cycle, the error wins and STKERR = 1.
  - STKERR is registered and rises 1 cycle after the offending edge's inputs.
- STKFULL = (sp == STACK_DEPTH) and STKEMPTY = (sp == 0), both decoded from the registered sp.
- sp width is clog2(STACK_DEPTH+1). sp never wraps.
- LDLVL/ACTLVL values >= LEVELS (non-power-of-2 misuse) are unsupported. Elaboration checks LVL_W == clog2(LEVELS).
- No combinational path from any input to any output.

Test Plan:
- Reset with sys_rst pulsed mid-cycle: outputs go to their reset values immediately. After release, SEG=0x00, SEGZN=0, STKEMPTY=1.
- LLDSEG with LDLVL=3, FIDBO=0xA5, ACTLVL=3: next cycle SEG=0xA5, SEGZN=1. Then ACTLVL=5: next cycle SEG=0x00, SEGZN=0.
- Load bank[2]=0x11, then SAVE at ACTLVL=2 with LLDSEG writing 0x22 to level 2 in the same cycle: SEG=0x22. A later RESTORE at ACTLVL=2 gives SEG=0x11 and STKEMPTY=1.
- Fill the stack with STACK_DEPTH=4 saves: STKFULL=1. A 5th SAVE sets STKERR=1 and sp stays 4. Four restores return the saved values in LIFO order.
- RESTORE with the stack empty: STKERR=1 and the bank is unchanged. CLRERR clears it; CLRERR together with a new underflow leaves STKERR=1.
- SAVE and RESTORE together with sp=2: sp stays 2 and STKERR=1. RESTORE together with LLDSEG (0x7F) to the same level: SEG=0x7F and sp decrements.
